fetch_buffer_cu: RTL and testbench

// Parametrised successor fetch unit: pipelined multi-byte reads from instruction memory into a circular byte queue.

---
 rtl/fetch_buffer_cu.sv | 166 ++++++++++++++++
 tb/tb_fetch_buffer_cu.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_buffer_cu.sv
// fetch_buffer_cu: pipelined instruction fetch into a circular byte queue,
// extracting one fixed- or variable-length instruction per cycle for decode.
module fetch_buffer_cu #(
  parameter int          FETCH_BYTES = 4,
  parameter int          QDEPTH      = 16,
  parameter int          NREDIR      = 3,
  parameter logic [31:0] RESET_PC    = 32'h0,
  parameter logic        RESET_MODE  = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     imem_req,
  output logic [31:0]              imem_addr,
  input  logic [8*FETCH_BYTES-1:0] imem_rdata,
  input  logic [NREDIR-1:0]        redir_valid,
  input  logic [32*NREDIR-1:0]     redir_pc,
  input  logic [NREDIR-1:0]        redir_mode,
  output logic                     inst_valid,
  input  logic                     inst_ready,
  output logic [47:0]              inst,
  output logic [31:0]              inst_pc,
  output logic [2:0]               inst_len,
  output logic                     inst_mode,
  output logic [31:0]              inst_next_pc
);

  localparam int AW = $clog2(QDEPTH);  // queue index width
  localparam int CW = AW + 1;          // occupancy count width (0..QDEPTH)
  localparam int SW = AW + 2;          // headroom for occupancy + outstanding read

  logic [7:0]    qmem [QDEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   inst_pc_q, inst_pc_d;
  logic          mode_q, mode_d;
  logic          pending_q, pending_d;
  logic          discard_q, discard_d;

  logic          redir_any;
  logic [31:0]   redir_sel_pc;
  logic          redir_sel_mode;
  logic [7:0]    peek [6];
  logic [SW-1:0] occupancy;
  logic          push, pop;

  // Decode mode 1 length from the opcode nibble of byte0; mode 0 is always 4.
  function automatic logic [2:0] len_of(input logic md, input logic [3:0] nib);
    logic [2:0] l;
    if (!md) begin
      l = 3'd4;
    end else begin
      case (nib)
        4'h2, 4'h6, 4'hA, 4'hB: l = 3'd2;
        4'h3, 4'h4, 4'h5:       l = 3'd6;
        4'h7, 4'h8, 4'hC:       l = 3'd5;
        default:                l = 3'd1;
      endcase
    end
    return l;
  endfunction

  // Redirect arbitration: lowest-index valid channel wins.
  always_comb begin
    redir_any      = |redir_valid;
    redir_sel_pc   = '0;
    redir_sel_mode = 1'b0;
    for (int i = NREDIR - 1; i >= 0; i--) begin
      if (redir_valid[i]) begin
        redir_sel_pc   = redir_pc[32*i +: 32];
        redir_sel_mode = redir_mode[i];
      end
    end
  end

  // Look at the six bytes starting at head (QDEPTH >= 6 so they never alias).
  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_peek
      logic [AW-1:0] idx;
      assign idx       = head_q + AW'(gi);
      assign peek[gi]  = qmem[idx];
      assign inst[8*gi +: 8] = (3'(gi) < inst_len) ? peek[gi] : 8'h00;
    end
  endgenerate

  assign inst_len     = len_of(mode_q, peek[0][7:4]);
  assign inst_pc      = inst_pc_q;
  assign inst_mode    = mode_q;
  assign inst_next_pc = inst_pc_q + 32'(inst_len);
  assign imem_addr    = fetch_pc_q;

  // Only issue when the queue is guaranteed room for this and any in-flight read.
  assign occupancy  = SW'(count_q) + (pending_q ? SW'(FETCH_BYTES) : '0) + SW'(FETCH_BYTES);
  assign imem_req   = !reset && !redir_any && (occupancy <= SW'(QDEPTH));
  assign inst_valid = !reset && !redir_any && (count_q >= CW'(inst_len));
  assign push       = pending_q && !discard_q;
  assign pop        = inst_valid && inst_ready;

  // Next-state: a redirect flushes everything; otherwise push, pop and issue.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    fetch_pc_d = fetch_pc_q;
    inst_pc_d  = inst_pc_q;
    mode_d     = mode_q;
    pending_d  = 1'b0;
    discard_d  = 1'b0;
    if (redir_any) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      fetch_pc_d = redir_sel_pc;
      inst_pc_d  = redir_sel_pc;
      mode_d     = redir_sel_mode;
      discard_d  = pending_q;
    end else begin
      if (push) begin
        tail_d = tail_q + AW'(FETCH_BYTES);
      end
      if (pop) begin
        head_d    = head_q + AW'(inst_len);
        inst_pc_d = inst_pc_q + 32'(inst_len);
      end
      count_d = count_q + (push ? CW'(FETCH_BYTES) : '0) - (pop ? CW'(inst_len) : '0);
      if (imem_req) begin
        pending_d  = 1'b1;
        fetch_pc_d = fetch_pc_q + 32'(FETCH_BYTES);
      end
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      fetch_pc_q <= RESET_PC;
      inst_pc_q  <= RESET_PC;
      mode_q     <= RESET_MODE;
      pending_q  <= 1'b0;
      discard_q  <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      fetch_pc_q <= fetch_pc_d;
      inst_pc_q  <= inst_pc_d;
      mode_q     <= mode_d;
      pending_q  <= pending_d;
      discard_q  <= discard_d;
    end
  end

  // Byte storage: the read response lands at tail, one byte per slot.
  always_ff @(posedge clk) begin
    if (!reset && !redir_any && push) begin
      for (int k = 0; k < FETCH_BYTES; k++) begin
        qmem[tail_q + AW'(k)] <= imem_rdata[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_fetch_buffer_cu.sv
// tb_fetch_buffer_cu: random and directed stimulus against a byte-queue
// reference model of the fetch unit, with a memory responder.
module tb_fetch_buffer_cu;

  localparam int FB = 4;
  localparam int QD = 16;
  localparam int NR = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          imem_req;
  logic [31:0]   imem_addr;
  logic [8*FB-1:0] imem_rdata;
  logic [NR-1:0] redir_valid;
  logic [32*NR-1:0] redir_pc;
  logic [NR-1:0] redir_mode;
  logic          inst_valid;
  logic          inst_ready;
  logic [47:0]   inst;
  logic [31:0]   inst_pc;
  logic [2:0]    inst_len;
  logic          inst_mode;
  logic [31:0]   inst_next_pc;

  always #5 clk = ~clk;

  fetch_buffer_cu #(.FETCH_BYTES(FB), .QDEPTH(QD), .NREDIR(NR),
                    .RESET_PC(32'h0), .RESET_MODE(1'b0)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redir_valid(redir_valid), .redir_pc(redir_pc),
    .redir_mode(redir_mode), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc), .inst_len(inst_len), .inst_mode(inst_mode),
    .inst_next_pc(inst_next_pc)
  );

  int total = 0;
  int bad   = 0;
  bit chk   = 0;

  logic [7:0]  mem [4096];
  logic        prev_req = 1'b0;
  logic [31:0] prev_addr = '0;

  // Reference model state
  logic [7:0]  mq [$];
  logic [31:0] m_fpc, m_ipc, m_paddr;
  bit          m_mode, m_pend;

  // Observed values of the most recently sampled cycle
  logic        o_req, o_valid, o_mode;
  logic [31:0] o_addr, o_pc;
  logic [2:0]  o_len;
  logic [47:0] o_inst;

  function automatic logic [31:0] memword(input logic [31:0] a);
    logic [31:0] w;
    logic [31:0] t;
    w = '0;
    for (int k = 0; k < FB; k++) begin
      t = a + 32'(k);
      w[8*k +: 8] = mem[t[11:0]];
    end
    return w;
  endfunction

  function automatic int ref_len(input bit md, input logic [7:0] b0);
    if (!md) return 4;
    case (b0[7:4])
      4'h2, 4'h6, 4'hA, 4'hB: return 2;
      4'h3, 4'h4, 4'h5:       return 6;
      4'h7, 4'h8, 4'hC:       return 5;
      default:                return 1;
    endcase
  endfunction

  // One clock cycle: drive memory response, compare against model, advance model.
  task automatic step();
    int          e_len;
    bit          e_valid, e_req;
    logic [47:0] e_inst;
    logic [31:0] t;
    int          w;
    imem_rdata = prev_req ? memword(prev_addr) : $urandom;
    #1;
    e_len   = (mq.size() > 0) ? ref_len(m_mode, mq[0]) : 1;
    e_valid = !reset && (redir_valid == '0) && (mq.size() > 0) && (mq.size() >= e_len);
    e_req   = !reset && (redir_valid == '0) && (mq.size() + (m_pend ? FB : 0) + FB <= QD);
    e_inst  = '0;
    if (e_valid) for (int k = 0; k < e_len; k++) e_inst[8*k +: 8] = mq[k];
    o_req = imem_req; o_addr = imem_addr; o_valid = inst_valid; o_mode = inst_mode;
    o_pc = inst_pc; o_len = inst_len; o_inst = inst;
    if (chk) begin
      total++;
      if (imem_req !== e_req) begin
        bad++; $display("FAIL imem_req t=%0t got=%b exp=%b", $time, imem_req, e_req);
      end
      if (e_req) begin
        total++;
        if (imem_addr !== m_fpc) begin
          bad++; $display("FAIL imem_addr t=%0t got=%h exp=%h", $time, imem_addr, m_fpc);
        end
      end
      total++;
      if (inst_valid !== e_valid) begin
        bad++; $display("FAIL inst_valid t=%0t got=%b exp=%b", $time, inst_valid, e_valid);
      end
      total++;
      if (inst_mode !== m_mode) begin
        bad++; $display("FAIL inst_mode t=%0t got=%b exp=%b", $time, inst_mode, m_mode);
      end
      if (e_valid) begin
        total++;
        if (inst_pc !== m_ipc || inst_len !== 3'(e_len) || inst !== e_inst ||
            inst_next_pc !== m_ipc + 32'(e_len)) begin
          bad++;
          $display("FAIL inst t=%0t got pc=%h len=%0d inst=%h npc=%h exp pc=%h len=%0d inst=%h",
                   $time, inst_pc, inst_len, inst, inst_next_pc, m_ipc, e_len, e_inst);
        end
      end
    end
    prev_req  = imem_req;
    prev_addr = imem_addr;
    // model update at the coming edge
    if (reset) begin
      mq.delete(); m_fpc = 32'h0; m_ipc = 32'h0; m_mode = 1'b0; m_pend = 1'b0;
    end else if (redir_valid != '0) begin
      w = 0;
      for (int i = NR - 1; i >= 0; i--) if (redir_valid[i]) w = i;
      mq.delete();
      m_fpc = redir_pc[32*w +: 32]; m_ipc = m_fpc; m_mode = redir_mode[w]; m_pend = 1'b0;
    end else begin
      if (e_valid && inst_ready) begin
        for (int k = 0; k < e_len; k++) void'(mq.pop_front());
        m_ipc = m_ipc + 32'(e_len);
      end
      if (m_pend) for (int k = 0; k < FB; k++) begin
        t = m_paddr + 32'(k);
        mq.push_back(mem[t[11:0]]);
      end
      if (e_req) begin
        m_pend = 1'b1; m_paddr = m_fpc; m_fpc = m_fpc + FB;
      end else begin
        m_pend = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4096; i++) mem[i] = 8'(i);
    reset = 1'b1; inst_ready = 1'b1; redir_valid = '0; redir_pc = '0; redir_mode = '0;
    @(negedge clk);
    step();
    chk = 1;
    step();
    total++;
    if (o_req !== 1'b0 || o_valid !== 1'b0 || o_mode !== 1'b0) begin
      bad++; $display("FAIL reset_outputs req=%b valid=%b mode=%b exp 0 0 0", o_req, o_valid, o_mode);
    end
    reset = 1'b0;
    step();
    total++;
    if (o_req !== 1'b1 || o_addr !== 32'h0) begin
      bad++; $display("FAIL first_req req=%b addr=%h exp 1 00000000", o_req, o_addr);
    end
    step();
    total++;
    if (o_req !== 1'b1 || o_addr !== 32'h4) begin
      bad++; $display("FAIL second_req req=%b addr=%h exp 1 00000004", o_req, o_addr);
    end
    step();
    total++;
    if (o_valid !== 1'b1 || o_inst !== 48'h0000_0302_0100 || o_pc !== 32'h0 || o_len !== 3'd4) begin
      bad++; $display("FAIL first_inst valid=%b inst=%h pc=%h len=%0d exp 1 000003020100 0 4",
                      o_valid, o_inst, o_pc, o_len);
    end
  endtask

  task automatic test_stream();
    int          nvalid;
    logic [31:0] last_pc;
    nvalid = 0; last_pc = 32'hFFFF_FFFF;
    for (int i = 0; i < 10; i++) begin
      step();
      if (o_valid) begin
        if (nvalid > 0) begin
          total++;
          if (o_pc !== last_pc + 32'd4) begin
            bad++; $display("FAIL stream_pc got=%h exp=%h", o_pc, last_pc + 32'd4);
          end
        end
        nvalid++; last_pc = o_pc;
      end
    end
    total++;
    if (nvalid != 10) begin
      bad++; $display("FAIL stream_gapless got=%0d valid cycles exp=10", nvalid);
    end
  endtask

  task automatic test_stall();
    logic [47:0] s_inst;
    logic [31:0] s_pc;
    inst_ready = 1'b0;
    step();
    s_inst = o_inst; s_pc = o_pc;
    for (int i = 0; i < 19; i++) begin
      step();
      total++;
      if (o_valid !== 1'b1 || o_inst !== s_inst || o_pc !== s_pc) begin
        bad++; $display("FAIL stall_hold valid=%b inst=%h pc=%h exp 1 %h %h", o_valid, o_inst, o_pc, s_inst, s_pc);
      end
    end
    total++;
    if (o_req !== 1'b0) begin
      bad++; $display("FAIL stall_full_req got=%b exp=0", o_req);
    end
    inst_ready = 1'b1;
    step();
    step();
    total++;
    if (o_valid !== 1'b1 || o_pc !== s_pc + 32'd4) begin
      bad++; $display("FAIL release_next valid=%b pc=%h exp 1 %h", o_valid, o_pc, s_pc + 32'd4);
    end
  endtask

  task automatic test_mode1();
    logic [7:0]  pat [9];
    logic [31:0] cpc [3];
    logic [2:0]  clen [3];
    logic [47:0] cinst [3];
    int          n;
    pat = '{8'h30, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'h10, 8'h20, 8'h55};
    for (int i = 0; i < 9; i++) mem[12'h40 + i] = pat[i];
    redir_valid = 3'b001; redir_pc = {32'h0, 32'h0, 32'h40}; redir_mode = 3'b001;
    step();
    redir_valid = '0;
    n = 0;
    for (int i = 0; i < 30 && n < 3; i++) begin
      step();
      if (o_valid) begin
        cpc[n] = o_pc; clen[n] = o_len; cinst[n] = o_inst; n++;
      end
    end
    total++;
    if (n != 3) begin
      bad++; $display("FAIL mode1_timeout got=%0d insts exp=3", n);
    end else begin
      total++;
      if (cpc[0] !== 32'h40 || clen[0] !== 3'd6 || cinst[0] !== 48'hEEDD_CCBB_AA30) begin
        bad++; $display("FAIL mode1_i0 pc=%h len=%0d inst=%h exp 40 6 eeddccbbaa30", cpc[0], clen[0], cinst[0]);
      end
      total++;
      if (cpc[1] !== 32'h46 || clen[1] !== 3'd1 || cinst[1] !== 48'h10) begin
        bad++; $display("FAIL mode1_i1 pc=%h len=%0d inst=%h exp 46 1 10", cpc[1], clen[1], cinst[1]);
      end
      total++;
      if (cpc[2] !== 32'h47 || clen[2] !== 3'd2 || cinst[2] !== 48'h5520) begin
        bad++; $display("FAIL mode1_i2 pc=%h len=%0d inst=%h exp 47 2 5520", cpc[2], clen[2], cinst[2]);
      end
    end
  endtask

  task automatic test_redirect();
    bit found;
    redir_mode = 3'b000;
    redir_valid = 3'b001; redir_pc = {32'h0, 32'h0, 32'h80};
    step();
    redir_valid = '0;
    for (int i = 0; i < 10 && !o_req; i++) step();
    redir_valid = 3'b110; redir_pc = {32'h200, 32'h100, 32'h0}; redir_mode = 3'b010;
    step();
    redir_valid = '0; redir_mode = '0;
    step();
    total++;
    if (o_req !== 1'b1 || o_addr !== 32'h100 || o_mode !== 1'b1 || o_valid !== 1'b0) begin
      bad++; $display("FAIL redir_req req=%b addr=%h mode=%b valid=%b exp 1 100 1 0", o_req, o_addr, o_mode, o_valid);
    end
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      found = o_valid;
    end
    total++;
    if (!found || o_pc !== 32'h100) begin
      bad++; $display("FAIL redir_first_pc found=%b pc=%h exp 1 100", found, o_pc);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 10 && !o_req; i++) step();
    reset = 1'b1;
    step();
    total++;
    if (o_req !== 1'b0 || o_valid !== 1'b0) begin
      bad++; $display("FAIL reset_mid_gate req=%b valid=%b exp 0 0", o_req, o_valid);
    end
    reset = 1'b0;
    step();
    total++;
    if (o_valid !== 1'b0 || o_req !== 1'b1 || o_addr !== 32'h0 || o_mode !== 1'b0) begin
      bad++; $display("FAIL reset_mid_after valid=%b req=%b addr=%h mode=%b exp 0 1 0 0", o_valid, o_req, o_addr, o_mode);
    end
    for (int i = 0; i < 6; i++) step();
  endtask

  task automatic test_random();
    logic [31:0] p;
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    for (int c = 0; c < 3000; c++) begin
      inst_ready = ($urandom_range(0, 3) != 0);
      reset      = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 19) == 0) begin
        redir_valid = 3'($urandom_range(1, 7));
        for (int i = 0; i < NR; i++) begin
          p = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7))
                                          : ($urandom & 32'hFFF);
          redir_pc[32*i +: 32] = p;
        end
        redir_mode = 3'($urandom);
      end else begin
        redir_valid = '0;
      end
      step();
    end
    reset = 1'b0; redir_valid = '0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_mode1();
    test_redirect();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
